// File: rtl/fft_frame_scheduler_if.sv
// Stream bundle between the filter output, the frame scheduler and the FFT core.
// The scheduler takes the master view; the filter/FFT environment takes the slave view.
interface fft_frame_scheduler_if #(
   parameter int AXIS_TDATA_WIDTH = 16
);
   logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_filter_tdata;
   logic                        S_AXIS_filter_tvalid;
   logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_fft_tdata;
   logic                        M_AXIS_fft_tvalid;
   logic                        M_AXIS_fft_tready;
   logic                        M_AXIS_fft_tlast;
   logic                        avg_first;
   logic                        avg_last;

   modport master (
      input  S_AXIS_filter_tdata, S_AXIS_filter_tvalid, M_AXIS_fft_tready,
      output M_AXIS_fft_tdata, M_AXIS_fft_tvalid, M_AXIS_fft_tlast, avg_first, avg_last
   );

   modport slave (
      output S_AXIS_filter_tdata, S_AXIS_filter_tvalid, M_AXIS_fft_tready,
      input  M_AXIS_fft_tdata, M_AXIS_fft_tvalid, M_AXIS_fft_tlast, avg_first, avg_last
   );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Cuts the filter stream into FFT frames, forwards 1 of 2^LT frames and tags averaging groups.
// Define FFT_SCHED_DROP_CNT_EN to add the saturating drop_count output.
module fft_frame_scheduler #(
   parameter int AXIS_TDATA_WIDTH = 16,
   parameter int LOG_FRAME_LEN    = 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [31:0]           GPIO,
   fft_frame_scheduler_if.master bus,
   output logic                  busy,
`ifdef FFT_SCHED_DROP_CNT_EN
   output logic [31:0]           drop_count,
`endif
   output logic                  overflow
);

   typedef enum logic [1:0] {IDLE, PASS, SKIP} state_e;
   localparam logic [LOG_FRAME_LEN-1:0] SMP_LAST = '1;

   state_e                      state_q, state_d;
   logic [LOG_FRAME_LEN-1:0]    smp_cnt_q, smp_cnt_d;
   logic [31:0]                 thr_cnt_q, thr_cnt_d;
   logic [31:0]                 avg_cnt_q, avg_cnt_d;
   logic [4:0]                  la_q, la_d, lt_q, lt_d;
   logic                        corrupt_q, corrupt_d;
   logic                        overflow_q, overflow_d;
   logic                        en_q;
   logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                        tvalid_q, tvalid_d;
   logic                        tlast_q, tlast_d;
   logic                        first_q, first_d;
   logic                        last_q, last_d;

   logic        en, rise, idle, beat, fwd, load, drop, boundary;
   logic [4:0]  la_eff, lt_eff;
   logic [31:0] la_mask, lt_mask, thr_next, avg_next;
   logic        gpio_unused;

   assign gpio_unused = ^GPIO[31:11];

   assign en   = GPIO[0];
   assign rise = en && !en_q;
   assign idle = (state_q == IDLE);

   // While idle the live GPIO fields govern the frame that is about to start.
   assign la_eff  = idle ? GPIO[5:1]  : la_q;
   assign lt_eff  = idle ? GPIO[10:6] : lt_q;
   assign la_mask = (32'd1 << la_eff) - 32'd1;
   assign lt_mask = (32'd1 << lt_eff) - 32'd1;

   assign beat     = bus.S_AXIS_filter_tvalid && (!idle || en);
   assign fwd      = beat && (state_q != SKIP);
   assign load     = fwd && (!tvalid_q || bus.M_AXIS_fft_tready);
   assign drop     = fwd && !load;
   assign boundary = beat && (smp_cnt_q == SMP_LAST);

   assign thr_next = (thr_cnt_q + 32'd1) & lt_mask;
   assign avg_next = (state_q != PASS)        ? avg_cnt_q :
                     (corrupt_q || drop)      ? 32'd0     :
                     (avg_cnt_q + 32'd1) & la_mask;

   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block infers a latch.
      state_d    = state_q;
      smp_cnt_d  = smp_cnt_q;
      thr_cnt_d  = thr_cnt_q;
      avg_cnt_d  = avg_cnt_q;
      la_d       = la_q;
      lt_d       = lt_q;
      corrupt_d  = corrupt_q;
      overflow_d = overflow_q;
      tdata_d    = tdata_q;
      tvalid_d   = tvalid_q;
      tlast_d    = tlast_q;
      first_d    = first_q;
      last_d     = last_q;

      if (beat) smp_cnt_d = smp_cnt_q + LOG_FRAME_LEN'(1);

      if (drop)      overflow_d = 1'b1;
      else if (rise) overflow_d = 1'b0;

      if (load) begin
         tdata_d  = bus.S_AXIS_filter_tdata;
         tvalid_d = 1'b1;
         tlast_d  = (smp_cnt_q == SMP_LAST);
         first_d  = (avg_cnt_q == 32'd0);
         last_d   = (avg_cnt_q == la_mask) && !corrupt_q;
      end else if (bus.M_AXIS_fft_tready) begin
         tvalid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            thr_cnt_d = '0;
            avg_cnt_d = '0;
            corrupt_d = drop;
            if (en) begin
               la_d = GPIO[5:1];
               lt_d = GPIO[10:6];
            end
            if (beat) state_d = PASS;
         end
         default: begin
            if (boundary) begin
               corrupt_d = 1'b0;
               if (!en) begin
                  state_d   = IDLE;
                  thr_cnt_d = '0;
                  avg_cnt_d = '0;
               end else begin
                  thr_cnt_d = thr_next;
                  avg_cnt_d = avg_next;
                  state_d   = (thr_next == 32'd0) ? PASS : SKIP;
                  // Config only changes where a group and a throttle period both start.
                  if (thr_next == 32'd0 && avg_next == 32'd0) begin
                     la_d = GPIO[5:1];
                     lt_d = GPIO[10:6];
                  end
               end
            end else if (drop) begin
               corrupt_d = 1'b1;
            end
         end
      endcase
   end

   // NOTE: non-blocking assignments here so every register samples pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         smp_cnt_q  <= '0;
         thr_cnt_q  <= '0;
         avg_cnt_q  <= '0;
         la_q       <= '0;
         lt_q       <= '0;
         corrupt_q  <= 1'b0;
         overflow_q <= 1'b0;
         en_q       <= 1'b0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         smp_cnt_q  <= smp_cnt_d;
         thr_cnt_q  <= thr_cnt_d;
         avg_cnt_q  <= avg_cnt_d;
         la_q       <= la_d;
         lt_q       <= lt_d;
         corrupt_q  <= corrupt_d;
         overflow_q <= overflow_d;
         en_q       <= en;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         first_q    <= first_d;
         last_q     <= last_d;
      end
   end

`ifdef FFT_SCHED_DROP_CNT_EN
   logic [31:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = rise ? 32'd0 : drop_cnt_q;
      if (drop && drop_cnt_d != 32'hFFFF_FFFF) drop_cnt_d = drop_cnt_d + 32'd1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) drop_cnt_q <= '0;
      else          drop_cnt_q <= drop_cnt_d;
   end

   assign drop_count = drop_cnt_q;
`endif

   assign bus.M_AXIS_fft_tdata  = tdata_q;
   assign bus.M_AXIS_fft_tvalid = tvalid_q;
   assign bus.M_AXIS_fft_tlast  = tlast_q;
   assign bus.avg_first         = first_q;
   assign bus.avg_last          = last_q;
   assign busy                  = !idle;
   assign overflow              = overflow_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Self-checking bench for fft_frame_scheduler (8-sample frames) against a frame-level reference model.
module tb_fft_frame_scheduler;
   localparam int W     = 16;
   localparam int LFL   = 3;
   localparam int FRAME = 1 << LFL;

   logic        aclk    = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] gpio    = '0;
   logic        busy, overflow;
`ifdef FFT_SCHED_DROP_CNT_EN
   logic [31:0] drop_count;
`endif

   fft_frame_scheduler_if #(.AXIS_TDATA_WIDTH(W)) bus ();

   fft_frame_scheduler #(.AXIS_TDATA_WIDTH(W), .LOG_FRAME_LEN(LFL)) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .GPIO       (gpio),
      .bus        (bus),
      .busy       (busy),
`ifdef FFT_SCHED_DROP_CNT_EN
      .drop_count (drop_count),
`endif
      .overflow   (overflow)
   );

   always #5 aclk = ~aclk;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   logic [W-1:0] ramp;
   bit           rnd_data;

   // Reference model: frames counted since the config epoch, pass frames counted within the group.
   bit           m_active, m_corrupt, m_prev_en, m_ovf;
   int           m_idx, m_la, m_lt;
   longint       m_k, m_p, m_drops;
   bit           m_v, m_last, m_first, m_alast;
   logic [W-1:0] m_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_corrupt = 0; m_prev_en = 0; m_ovf = 0;
      m_idx = 0; m_la = 0; m_lt = 0;
      m_k = 0; m_p = 0; m_drops = 0;
      m_v = 0; m_last = 0; m_first = 0; m_alast = 0; m_data = '0;
   endtask

   task automatic model_edge(input logic [31:0] g, input bit sv, input logic [W-1:0] sd, input bit tr);
      bit     en, pass, loaded;
      longint ga, gl;
      en     = g[0];
      loaded = 0;
      pass   = 0;
      if (en && !m_prev_en) begin
         m_ovf   = 0;
         m_drops = 0;
      end
      if (!m_active && en) begin
         m_la = int'(g[5:1]);
         m_lt = int'(g[10:6]);
         if (sv) begin
            m_active = 1; m_k = 0; m_p = 0; m_idx = 0; m_corrupt = 0;
         end
      end
      if (m_active && sv) begin
         ga   = longint'(1) << m_la;
         gl   = longint'(1) << m_lt;
         pass = (m_k % gl) == 0;
         if (pass) begin
            if (!m_v || tr) begin
               loaded  = 1;
               m_v     = 1;
               m_data  = sd;
               m_last  = (m_idx == FRAME - 1);
               m_first = (m_p % ga) == 0;
               m_alast = ((m_p % ga) == ga - 1) && !m_corrupt;
            end else begin
               m_ovf     = 1;
               m_corrupt = 1;
               if (m_drops < 64'd4294967295) m_drops++;
            end
         end
         if (m_idx == FRAME - 1) begin
            m_idx = 0;
            if (!en) begin
               m_active = 0;
            end else begin
               if (pass) m_p = m_corrupt ? 0 : m_p + 1;
               m_corrupt = 0;
               m_k++;
               if ((m_k % gl) == 0 && (m_p % ga) == 0) begin
                  m_la = int'(g[5:1]);
                  m_lt = int'(g[10:6]);
                  m_k  = 0;
                  m_p  = 0;
               end
            end
         end else begin
            m_idx++;
         end
      end
      if (!loaded && tr) m_v = 0;
      m_prev_en = en;
   endtask

   task automatic compare_outputs();
      check("busy",     32'(busy),                  32'(m_active));
      check("overflow", 32'(overflow),              32'(m_ovf));
      check("tvalid",   32'(bus.M_AXIS_fft_tvalid), 32'(m_v));
      if (m_v) begin
         check("tdata",     32'(bus.M_AXIS_fft_tdata), 32'(m_data));
         check("tlast",     32'(bus.M_AXIS_fft_tlast), 32'(m_last));
         check("avg_first", 32'(bus.avg_first),        32'(m_first));
         check("avg_last",  32'(bus.avg_last),         32'(m_alast));
      end
`ifdef FFT_SCHED_DROP_CNT_EN
      check("drop_count", drop_count, 32'(m_drops));
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"},   32'(bus.M_AXIS_fft_tvalid), 32'd0);
      check({tag, "_tdata"},    32'(bus.M_AXIS_fft_tdata),  32'd0);
      check({tag, "_tlast"},    32'(bus.M_AXIS_fft_tlast),  32'd0);
      check({tag, "_avg_first"},32'(bus.avg_first),         32'd0);
      check({tag, "_avg_last"}, 32'(bus.avg_last),          32'd0);
      check({tag, "_busy"},     32'(busy),                  32'd0);
      check({tag, "_overflow"}, 32'(overflow),              32'd0);
`ifdef FFT_SCHED_DROP_CNT_EN
      check({tag, "_drop_count"}, drop_count, 32'd0);
`endif
   endtask

   task automatic step(input logic [31:0] g, input bit sv, input bit tr);
      logic [W-1:0] sd;
      sd = rnd_data ? W'($urandom) : ramp;
      gpio                     = g;
      bus.S_AXIS_filter_tvalid = sv;
      bus.S_AXIS_filter_tdata  = sd;
      bus.M_AXIS_fft_tready    = tr;
      model_edge(g, sv, sd, tr);
      if (sv) ramp++;
      @(posedge aclk);
      #1;
      compare_outputs();
   endtask

   task automatic run(input int n, input logic [31:0] g, input int sv_pct, input int tr_pct);
      for (int i = 0; i < n; i++)
         step(g, $urandom_range(99) < sv_pct, $urandom_range(99) < tr_pct);
   endtask

   task automatic drain();
      run(FRAME + 4, 32'h0, 100, 100);
   endtask

   task automatic async_reset();
      #2;
      aresetn = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   initial begin
      bus.S_AXIS_filter_tdata  = '0;
      bus.S_AXIS_filter_tvalid = 1'b0;
      bus.M_AXIS_fft_tready    = 1'b0;
      rnd_data = 0;
      ramp     = '0;
      model_reset();

      #12;
      check_reset_outputs("reset");
      aresetn = 1'b1;

      // Every frame forwarded, disable lands mid-frame 3.
      ramp = '0;
      run(26, 32'h1, 100, 100);
      drain();

      // LT=1: every other frame forwarded.
      ramp = '0;
      run(40, 32'h41, 100, 100);
      drain();

      // LA=2: groups of four frames.
      ramp = '0;
      run(48, 32'h5, 100, 100);
      drain();

      // Disable at data 3: the frame still completes with tlast.
      ramp = '0;
      run(4, 32'h1, 100, 100);
      run(10, 32'h0, 100, 100);

      // Backpressure in frame 1 of an LA=2 group.
      ramp = '0;
      run(10, 32'h5, 100, 100);
      run(3, 32'h5, 100, 0);
      run(40, 32'h5, 100, 100);
      drain();

      // Widest fields: only frame 0 of 2^31 passes.
      ramp = '0;
      run(30, {21'h0, 5'd31, 5'd31, 1'b1}, 100, 100);
      drain();

      // Asynchronous reset at data 5, then restart from sample 0.
      ramp = '0;
      run(6, 32'h1, 100, 100);
      async_reset();
      ramp = '0;
      run(12, 32'h1, 100, 100);
      drain();

      // Randomized configs, valid gaps and backpressure; upper GPIO bits are noise.
      rnd_data = 1;
      for (int b = 0; b < 24; b++) begin
         logic [31:0] r;
         logic [31:0] g;
         r = $urandom;
         g = {r[31:11], 5'($urandom_range(2)), 5'($urandom_range(2)), 1'($urandom_range(4) != 0)};
         run(80, g, 80, 70);
      end
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
